// File: rtl/nasti_mem_tester.sv
// rtl/nasti_mem_tester.sv - NASTI master running write-then-read-back burst checks
//
// Purpose: after a start pulse, writes NUM_BURSTS INCR bursts of BURST_LEN beats
// with a deterministic pattern, reading each burst back right after its write
// response and checking every returned beat.
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   start_i            one-cycle run request (ignored while busy)
//   busy_o, done_o     run in progress / run finished (held until next start)
//   pass_o             done with zero errors
//   err_count_o        saturating failed-check count
//   aw_*, w_*, ar_*    write-address, write-data, read-address master channels
//   b_*, r_*           write-response, read-data channels (this block drives ready)
module nasti_mem_tester #(
  parameter int          ID_WIDTH   = 1,
  parameter int          ADDR_WIDTH = 16,
  parameter int          DATA_WIDTH = 128,
  parameter int          USER_WIDTH = 1,
  parameter int          BASE_ADDR  = 0,
  parameter int          NUM_BURSTS = 4,
  parameter int          BURST_LEN  = 8,
  parameter int          TX_ID      = 0,
  parameter logic [31:0] SEED       = 32'h1234_5678
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    pass_o,
  output logic [15:0]             err_count_o,
  output logic                    aw_valid_o,
  input  logic                    aw_ready_i,
  output logic [ID_WIDTH-1:0]     aw_id_o,
  output logic [ADDR_WIDTH-1:0]   aw_addr_o,
  output logic [7:0]              aw_len_o,
  output logic [2:0]              aw_size_o,
  output logic [1:0]              aw_burst_o,
  output logic [USER_WIDTH-1:0]   aw_user_o,
  output logic                    w_valid_o,
  input  logic                    w_ready_i,
  output logic [DATA_WIDTH-1:0]   w_data_o,
  output logic [DATA_WIDTH/8-1:0] w_strb_o,
  output logic                    w_last_o,
  output logic [USER_WIDTH-1:0]   w_user_o,
  input  logic                    b_valid_i,
  output logic                    b_ready_o,
  input  logic [ID_WIDTH-1:0]     b_id_i,
  input  logic [1:0]              b_resp_i,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic [ID_WIDTH-1:0]     ar_id_o,
  output logic [ADDR_WIDTH-1:0]   ar_addr_o,
  output logic [7:0]              ar_len_o,
  output logic [2:0]              ar_size_o,
  output logic [1:0]              ar_burst_o,
  output logic [USER_WIDTH-1:0]   ar_user_o,
  input  logic                    r_valid_i,
  output logic                    r_ready_o,
  input  logic [ID_WIDTH-1:0]     r_id_i,
  input  logic [DATA_WIDTH-1:0]   r_data_i,
  input  logic [1:0]              r_resp_i,
  input  logic                    r_last_i
);

  localparam int                  LANES      = DATA_WIDTH / 32;
  localparam int                  BEAT_BYTES = DATA_WIDTH / 8;
  localparam logic [2:0]          SIZE       = 3'($clog2(BEAT_BYTES));
  localparam logic [7:0]          LAST_BEAT  = 8'(BURST_LEN - 1);
  localparam logic [7:0]          LAST_BURST = 8'(NUM_BURSTS - 1);
  localparam logic [ID_WIDTH-1:0] TXID       = ID_WIDTH'(TX_ID);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  burst_q, burst_d, beat_q, beat_d;
  logic [15:0] err_q, err_d;
  logic        done_q, done_d, busy_q;
  logic        r_bad;

  // Lane k of global beat g carries SEED + g + k.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [7:0] burst, input logic [7:0] beat);
    logic [31:0]           g;
    logic [DATA_WIDTH-1:0] p;
    g = 32'(burst) * 32'(BURST_LEN) + 32'(beat);
    p = '0;
    for (int k = 0; k < LANES; k++) p[k*32 +: 32] = SEED + g + 32'(k);
    return p;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] burst_addr(input logic [7:0] burst);
    logic [63:0] a;
    a = 64'(BASE_ADDR) + 64'(burst) * 64'(BURST_LEN * BEAT_BYTES);
    return a[ADDR_WIDTH-1:0];
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, c} + 17'(n);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign r_bad = (r_data_i != pattern(burst_q, beat_q)) || (r_id_i != TXID) ||
                 (r_resp_i != 2'b00) || (r_last_i != (beat_q == LAST_BEAT));

  // Each state's valid/ready output is registered from state_d, so being in a
  // state implies that state's valid/ready is already high.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    err_d   = err_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        err_d   = '0;
        burst_d = '0;
        beat_d  = '0;
        done_d  = 1'b0;
        state_d = S_AW;
      end
      S_AW: if (aw_ready_i) state_d = S_W;
      S_W: if (w_ready_i) begin
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = S_B;
        end else begin
          beat_d = beat_q + 8'd1;
        end
      end
      S_B: if (b_valid_i) begin
        err_d   = sat_add(err_q, {1'b0, b_id_i != TXID} + {1'b0, b_resp_i != 2'b00});
        state_d = S_AR;
      end
      S_AR: if (ar_ready_i) state_d = S_R;
      S_R: if (r_valid_i) begin
        if (r_bad) err_d = sat_add(err_q, 2'd1);
        // An early r_last or the final expected beat both close the burst.
        if (r_last_i || beat_q == LAST_BEAT) begin
          beat_d = '0;
          if (burst_q == LAST_BURST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            burst_d = burst_q + 8'd1;
            state_d = S_AW;
          end
        end else begin
          beat_d = beat_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      burst_q    <= '0;
      beat_q     <= '0;
      err_q      <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      aw_valid_o <= 1'b0;
      w_valid_o  <= 1'b0;
      b_ready_o  <= 1'b0;
      ar_valid_o <= 1'b0;
      r_ready_o  <= 1'b0;
      aw_id_o    <= '0;
      aw_addr_o  <= '0;
      aw_len_o   <= '0;
      aw_size_o  <= '0;
      aw_burst_o <= '0;
      ar_id_o    <= '0;
      ar_addr_o  <= '0;
      ar_len_o   <= '0;
      ar_size_o  <= '0;
      ar_burst_o <= '0;
      w_data_o   <= '0;
      w_strb_o   <= '0;
      w_last_o   <= 1'b0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
      done_q     <= done_d;
      busy_q     <= (state_d != S_IDLE) && (state_d != S_DONE);
      aw_valid_o <= (state_d == S_AW);
      w_valid_o  <= (state_d == S_W);
      b_ready_o  <= (state_d == S_B);
      ar_valid_o <= (state_d == S_AR);
      r_ready_o  <= (state_d == S_R);
      // burst_d/beat_d only move on handshakes, so payloads stay stable while valid waits.
      if (state_d == S_AW) begin
        aw_id_o    <= TXID;
        aw_addr_o  <= burst_addr(burst_d);
        aw_len_o   <= LAST_BEAT;
        aw_size_o  <= SIZE;
        aw_burst_o <= 2'b01;
      end
      if (state_d == S_AR) begin
        ar_id_o    <= TXID;
        ar_addr_o  <= burst_addr(burst_d);
        ar_len_o   <= LAST_BEAT;
        ar_size_o  <= SIZE;
        ar_burst_o <= 2'b01;
      end
      if (state_d == S_W) begin
        w_data_o <= pattern(burst_d, beat_d);
        w_strb_o <= '1;
        w_last_o <= (beat_d == LAST_BEAT);
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_count_o = err_q;
  assign pass_o      = done_q && (err_q == 16'd0);
  assign aw_user_o   = '0;
  assign w_user_o    = '0;
  assign ar_user_o   = '0;

endmodule
